// File: rtl/cpu_pkg.sv
// Shared definitions for the pipelined miniCPU: widths, special instructions,
// the fetch-state encoding and the IF/ID bundle used by the later stages.
package cpu_pkg;

    localparam int          CPU_XLEN        = 32;
    localparam logic [31:0] CPU_NOP_INST    = 32'h0000_0013;
    localparam logic [31:0] CPU_EBREAK_INST = 32'h0010_0073;

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } fetch_state_e;

    typedef struct packed {
        logic [CPU_XLEN-1:0] pc;
        logic [CPU_XLEN-1:0] pc4;
        logic [31:0]         inst;
        logic                valid;
    } if_id_t;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register. Priority per edge: reset > bubble > load > hold.
// A bubble replaces the instruction with a NOP but keeps pc/pc4 as they were.
module if_id_reg
    import cpu_pkg::*;
#(
    parameter int          XLEN     = CPU_XLEN,
    parameter logic [31:0] NOP_INST = CPU_NOP_INST
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            load_i,
    input  logic            bubble_i,
    input  logic [XLEN-1:0] pc_i,
    input  logic [31:0]     inst_i,
    output logic [XLEN-1:0] pc_o,
    output logic [XLEN-1:0] pc4_o,
    output logic [31:0]     inst_o,
    output logic            valid_o
);

    logic [XLEN-1:0] pc_q,    pc_d;
    logic [XLEN-1:0] pc4_q,   pc4_d;
    logic [31:0]     inst_q,  inst_d;
    logic            valid_q, valid_d;

    always_comb begin
        pc_d    = pc_q;
        pc4_d   = pc4_q;
        inst_d  = inst_q;
        valid_d = valid_q;
        if (bubble_i) begin
            inst_d  = NOP_INST;
            valid_d = 1'b0;
        end else if (load_i) begin
            pc_d    = pc_i;
            pc4_d   = pc_i + XLEN'(4);
            inst_d  = inst_i;
            valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_q    <= '0;
            pc4_q   <= '0;
            inst_q  <= NOP_INST;
            valid_q <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            pc4_q   <= pc4_d;
            inst_q  <= inst_d;
            valid_q <= valid_d;
        end
    end

    assign pc_o    = pc_q;
    assign pc4_o   = pc4_q;
    assign inst_o  = inst_q;
    assign valid_o = valid_q;

endmodule

// File: rtl/if_pipe_stage.sv
// Instruction-fetch stage: PC register, RUN/HALT fetch FSM, redirect/stall
// priority and the IF/ID register. Define FETCH_STAT_EN for fetch statistics.
module if_pipe_stage
    import cpu_pkg::*;
#(
    parameter int              XLEN        = CPU_XLEN,
    parameter logic [XLEN-1:0] RESET_PC    = '0,
    parameter logic [31:0]     NOP_INST    = CPU_NOP_INST,
    parameter logic [31:0]     EBREAK_INST = CPU_EBREAK_INST,
    parameter int              CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             stall,
    input  logic             redirect_valid,
    input  logic [XLEN-1:0]  redirect_pc,
    input  logic [31:0]      irom_inst,
    output logic [XLEN-1:0]  pc,
    output logic [XLEN-1:0]  if_id_pc,
    output logic [XLEN-1:0]  if_id_pc4,
    output logic [31:0]      if_id_inst,
    output logic             if_id_valid,
`ifdef FETCH_STAT_EN
    output logic [CNT_W-1:0] fetch_cnt,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
`endif
    output logic             halted
);

    logic [XLEN-1:0] pc_q, pc_d;
    fetch_state_e    state_q, state_d;
    logic            load, bubble;

    // Priority: redirect > stall > HALT > RUN fetch (reset handled in the flops).
    always_comb begin
        pc_d    = pc_q;
        state_d = state_q;
        load    = 1'b0;
        bubble  = 1'b0;
        if (redirect_valid) begin
            pc_d    = redirect_pc & ~XLEN'(3);
            bubble  = 1'b1;
            state_d = RUN;
        end else if (stall) begin
            pc_d    = pc_q;
        end else if (state_q == HALT) begin
            bubble  = 1'b1;
        end else begin
            load = 1'b1;
            if (irom_inst == EBREAK_INST) begin
                state_d = HALT;
            end else begin
                pc_d = pc_q + XLEN'(4);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_q    <= RESET_PC;
            state_q <= RUN;
        end else begin
            pc_q    <= pc_d;
            state_q <= state_d;
        end
    end

    if_id_reg #(
        .XLEN     (XLEN),
        .NOP_INST (NOP_INST)
    ) u_if_id_reg (
        .clk      (clk),
        .rst_n    (rst_n),
        .load_i   (load),
        .bubble_i (bubble),
        .pc_i     (pc_q),
        .inst_i   (irom_inst),
        .pc_o     (if_id_pc),
        .pc4_o    (if_id_pc4),
        .inst_o   (if_id_inst),
        .valid_o  (if_id_valid)
    );

    assign pc     = pc_q;
    assign halted = (state_q == HALT);

`ifdef FETCH_STAT_EN
    logic [CNT_W-1:0] fetch_cnt_q, stall_cnt_q, flush_cnt_q;

    // Counters saturate at all-ones rather than wrapping.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fetch_cnt_q <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (load && fetch_cnt_q != '1)
                fetch_cnt_q <= fetch_cnt_q + CNT_W'(1);
            if (stall && !redirect_valid && stall_cnt_q != '1)
                stall_cnt_q <= stall_cnt_q + CNT_W'(1);
            if (redirect_valid && flush_cnt_q != '1)
                flush_cnt_q <= flush_cnt_q + CNT_W'(1);
        end
    end

    assign fetch_cnt = fetch_cnt_q;
    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_if_pipe_stage.sv
// Scoreboard bench for if_pipe_stage: directed steps push the expected
// post-edge snapshot; a negedge monitor pops and compares.
module tb_if_pipe_stage;

    localparam int W = 32 * 4 + 2;

    logic        clk;
    logic        rst_n;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [31:0] irom_inst;
    logic [31:0] pc;
    logic [31:0] if_id_pc;
    logic [31:0] if_id_pc4;
    logic [31:0] if_id_inst;
    logic        if_id_valid;
    logic        halted;
`ifdef FETCH_STAT_EN
    logic [31:0] fetch_cnt, stall_cnt, flush_cnt;
`endif

    if_pipe_stage dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .irom_inst      (irom_inst),
        .pc             (pc),
        .if_id_pc       (if_id_pc),
        .if_id_pc4      (if_id_pc4),
        .if_id_inst     (if_id_inst),
        .if_id_valid    (if_id_valid),
`ifdef FETCH_STAT_EN
        .fetch_cnt      (fetch_cnt),
        .stall_cnt      (stall_cnt),
        .flush_cnt      (flush_cnt),
`endif
        .halted         (halted)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // scoreboard
    logic [W-1:0] exp_q[$];
    string        name_q[$];
    int           n_compared   = 0;
    int           n_mismatched = 0;

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            logic [W-1:0] exp_v;
            logic [W-1:0] act_v;
            string        nm;
            exp_v = exp_q.pop_front();
            nm    = name_q.pop_front();
            act_v = {pc, if_id_pc, if_id_pc4, if_id_inst, if_id_valid, halted};
            n_compared++;
            if (act_v !== exp_v) begin
                n_mismatched++;
                $display("FAIL %s: got pc=%h ipc=%h ipc4=%h inst=%h v=%b h=%b, want pc=%h ipc=%h ipc4=%h inst=%h v=%b h=%b",
                         nm, act_v[129:98], act_v[97:66], act_v[65:34], act_v[33:2], act_v[1], act_v[0],
                         exp_v[129:98], exp_v[97:66], exp_v[65:34], exp_v[33:2], exp_v[1], exp_v[0]);
            end
        end
    end

    // driver: apply inputs for one edge and record the expected result of it
    task automatic step(input string nm, input logic rst_v, input logic stall_v,
                        input logic redir_v, input logic [31:0] rpc_v, input logic [31:0] inst_v,
                        input logic [31:0] e_pc, input logic [31:0] e_ipc, input logic [31:0] e_ipc4,
                        input logic [31:0] e_inst, input logic e_valid, input logic e_halt);
        @(negedge clk);
        #1;
        rst_n          = rst_v;
        stall          = stall_v;
        redirect_valid = redir_v;
        redirect_pc    = rpc_v;
        irom_inst      = inst_v;
        exp_q.push_back({e_pc, e_ipc, e_ipc4, e_inst, e_valid, e_halt});
        name_q.push_back(nm);
    endtask

    localparam logic [31:0] ADDI = 32'h0050_0093;
    localparam logic [31:0] EBRK = 32'h0010_0073;
    localparam logic [31:0] NOP  = 32'h0000_0013;

    initial begin
        rst_n = 1'b0; stall = 1'b0; redirect_valid = 1'b0;
        redirect_pc = '0; irom_inst = ADDI;

        step("reset",        0, 0, 0, 0, ADDI, 32'h0, 32'h0, 32'h0, NOP, 0, 0);
        step("run0",         1, 0, 0, 0, ADDI, 32'h4, 32'h0, 32'h4, ADDI, 1, 0);
        step("run1",         1, 0, 0, 0, ADDI, 32'h8, 32'h4, 32'h8, ADDI, 1, 0);
        step("stall0",       1, 1, 0, 0, ADDI, 32'h8, 32'h4, 32'h8, ADDI, 1, 0);
        step("stall1",       1, 1, 0, 0, ADDI, 32'h8, 32'h4, 32'h8, ADDI, 1, 0);
        step("release",      1, 0, 0, 0, ADDI, 32'hC, 32'h8, 32'hC, ADDI, 1, 0);
        step("run2",         1, 0, 0, 0, ADDI, 32'h10, 32'hC, 32'h10, ADDI, 1, 0);
        step("redir_stall",  1, 1, 1, 32'h103, ADDI, 32'h100, 32'hC, 32'h10, NOP, 0, 0);
        step("redir_10",     1, 0, 1, 32'h10, ADDI, 32'h10, 32'hC, 32'h10, NOP, 0, 0);
        step("ebreak",       1, 0, 0, 0, EBRK, 32'h10, 32'h10, 32'h14, EBRK, 1, 1);
        step("halt_bub0",    1, 0, 0, 0, ADDI, 32'h10, 32'h10, 32'h14, NOP, 0, 1);
        step("halt_bub1",    1, 0, 0, 0, EBRK, 32'h10, 32'h10, 32'h14, NOP, 0, 1);
        step("halt_stall",   1, 1, 0, 0, ADDI, 32'h10, 32'h10, 32'h14, NOP, 0, 1);
        step("redir_40",     1, 0, 1, 32'h40, ADDI, 32'h40, 32'h10, 32'h14, NOP, 0, 0);
        step("run_40",       1, 0, 0, 0, ADDI, 32'h44, 32'h40, 32'h44, ADDI, 1, 0);
        step("ebreak2",      1, 0, 0, 0, EBRK, 32'h44, 32'h44, 32'h48, EBRK, 1, 1);
        step("rst_halt_stl", 0, 1, 0, 0, EBRK, 32'h0, 32'h0, 32'h0, NOP, 0, 0);
        step("redir_top",    1, 0, 1, 32'hFFFF_FFFE, ADDI, 32'hFFFF_FFFC, 32'h0, 32'h0, NOP, 0, 0);
        step("wrap",         1, 0, 0, 0, ADDI, 32'h0, 32'hFFFF_FFFC, 32'h0, ADDI, 1, 0);
        step("after_wrap",   1, 0, 0, 0, ADDI, 32'h4, 32'h0, 32'h4, ADDI, 1, 0);
        step("stall_ebrk",   1, 1, 0, 0, EBRK, 32'h4, 32'h0, 32'h4, ADDI, 1, 0);
        step("run_after",    1, 0, 0, 0, ADDI, 32'h8, 32'h4, 32'h8, ADDI, 1, 0);

        @(negedge clk);
        #1;
        stall = 1'b1;
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
        if (exp_q.size() > 0) begin
            n_compared++;
            n_mismatched++;
            $display("FAIL drain: %0d expected entries left, want 0", exp_q.size());
        end

`ifdef FETCH_STAT_EN
        // since the last reset: 3 fetches, 1 stall (before this drain), 1 redirect
        n_compared++;
        if (fetch_cnt !== 32'd3 || flush_cnt !== 32'd1) begin
            n_mismatched++;
            $display("FAIL stat_cnt: got fetch=%0d flush=%0d, want fetch=3 flush=1", fetch_cnt, flush_cnt);
        end
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule

// File: doc/if_pipe_stage.md
Name: if_pipe_stage

Overview:
Parametrised instruction-fetch stage for the pipelined successor of the single-cycle miniCPU. Holds the PC and drives it to the combinational IROM. Registers the fetched instruction into an IF/ID pipeline register and accepts stall from the hazard unit and redirect/flush from EX. Adds a halt-on-EBREAK state machine for on-board test programs.

Parameters:
XLEN, 32, PC and data width
RESET_PC, 32'h0000_0000, PC value loaded at reset
NOP_INST, 32'h0000_0013, bubble instruction (addi x0,x0,0)
EBREAK_INST, 32'h0010_0073, instruction that halts fetch
CNT_W, 32, statistic counter width (FETCH_STAT_EN only)

Ports:
clk  in  1  system clock, all state on rising edge
rst_n  in  1  synchronous active-low reset
stall  in  1  hazard unit: hold PC and IF/ID this cycle
redirect_valid  in  1  EX: branch/jump resolved taken, squash younger
redirect_pc  in  XLEN  EX: target address
irom_inst  in  32  IROM read data for pc (combinational)
pc  out  XLEN  current fetch PC, to IROM address
if_id_pc  out  XLEN  PC of instruction in IF/ID
if_id_pc4  out  XLEN  if_id_pc + 4, for JAL/JALR writeback
if_id_inst  out  32  instruction in IF/ID
if_id_valid  out  1  IF/ID holds a real instruction
halted  out  1  fetch halted on EBREAK

Behaviour:
- Clock and reset: one clock clk; synchronous active-low reset rst_n, sampled on the rising edge.
- Reset (rst_n=0 at edge): pc=RESET_PC, if_id_pc=0, if_id_pc4=0, if_id_inst=NOP_INST, if_id_valid=0, state=RUN, halted=0. Reset overrides everything, including mid-stall and mid-halt.
- FSM states: RUN, HALT. halted = (state==HALT), registered.
- Per-edge priority: reset > redirect_valid > stall > HALT > RUN fetch.
- redirect_valid=1: pc<=redirect_pc with bits[1:0] forced 0. IF/ID becomes a bubble (inst=NOP_INST, valid=0, pc/pc4 hold). State<=RUN, which cancels a HALT entered on a wrong path. A redirect overrides a simultaneous stall.
- stall=1, no redirect: pc, IF/ID and state all hold. An EBREAK on irom_inst is not acted on.
- HALT, no redirect/stall: pc holds. IF/ID is a bubble.
- RUN, no redirect/stall: if_id_pc<=pc, if_id_pc4<=pc+4, if_id_inst<=irom_inst, if_id_valid<=1.
  - If irom_inst==EBREAK_INST: pc holds and state<=HALT. The EBREAK itself still enters IF/ID as valid.
  - Otherwise pc<=pc+4.
- Latency: instruction at pc appears in IF/ID one edge after being fetched in RUN without stall.
- Arithmetic: pc+4 is modulo 2^XLEN. PC 0xFFFF_FFFC wraps to 0 with no flag.
- Outputs are registered. pc is the register value; there is no combinational path from inputs to outputs.

Optional Feature:
FETCH_STAT_EN
- Defined: adds outputs fetch_cnt, stall_cnt, flush_cnt, each CNT_W bits, reset to 0, saturating at all-ones.
  - fetch_cnt increments on each RUN fetch edge that writes a valid IF/ID.
  - stall_cnt increments on each edge with stall=1 and no redirect.
  - flush_cnt increments on each edge with redirect_valid=1.
- Undefined: the ports and counter logic are absent. All other behaviour is identical.

Decomposition:
- Shared package cpu_pkg holds:
  - the XLEN default, NOP_INST, EBREAK_INST
  - the fetch-state enum (RUN, HALT)
  - the IF/ID bundle typedef (pc, pc4, inst, valid), reused by the later ID/EX stages.
- One natural sub-module: if_id_reg, the IF/ID pipeline register with load/hold/bubble controls. if_pipe_stage owns the PC, the FSM, the priority logic and the optional counters.

Test Plan:
- Reset then 3 free-running cycles, IROM returns 0x00500093 at all PCs -> pc 0→4→8→C; after the first edge if_id_pc=0, if_id_pc4=4, if_id_valid=1.
- stall=1 for 2 cycles at pc=8 -> pc stays 8, IF/ID unchanged. Release -> if_id_pc=8, pc=C.
- redirect_valid=1, redirect_pc=0x103, with stall=1 at the same edge -> pc=0x100, if_id_valid=0, if_id_inst=0x13.
- IROM returns 0x00100073 at pc=0x10 -> if_id_inst=EBREAK with valid=1, then halted=1, pc held at 0x10, following IF/ID entries are bubbles. A redirect to 0x40 then gives halted=0 and pc=0x40.
- rst_n=0 while halted and stalled -> after the edge pc=RESET_PC, halted=0, if_id_valid=0. Also with pc=0xFFFFFFFC and no stall -> pc wraps to 0.
- FETCH_STAT_EN build: 5 fetches, 2 stalls, 1 redirect -> fetch_cnt=5, stall_cnt=2, flush_cnt=1. With CNT_W=2, 5 fetches saturate fetch_cnt at 3.
